// File: rtl/router_fsm_nch_if.sv
// rtl/router_fsm_nch_if.sv - handshake/status bundle between router datapath and router_fsm_nch
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              fifo_full;
  logic [ADDR_W-1:0] data_in;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] fifo_empty;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              drop_state;
  logic              write_enb_reg;
  logic              busy;
  logic [NUM_CH-1:0] dest_sel;
  logic              addr_err;
  logic              timeout_err;

  modport slave (
    input  pkt_valid, parity_done, low_pkt_valid, fifo_full, data_in, soft_reset, fifo_empty,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state,
    output write_enb_reg, busy, dest_sel, addr_err, timeout_err
  );

  modport master (
    output pkt_valid, parity_done, low_pkt_valid, fifo_full, data_in, soft_reset, fifo_empty,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, drop_state,
    input  write_enb_reg, busy, dest_sel, addr_err, timeout_err
  );
endinterface

// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - 1xN router control FSM with invalid-address drop and soft reset
// Optional wait-till-empty abort counter enabled by defining WAIT_TIMEOUT_EN.
module router_fsm_nch #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input logic             clk,
  input logic             resetn,
  router_fsm_nch_if.slave bus
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP               = 4'd8
  } state_t;

  localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W+1)'(NUM_CH);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_err;
  logic [NUM_CH-1:0] w_addr_oh;
  logic [NUM_CH-1:0] w_in_oh;
  logic              w_valid_in;
  logic              w_empty_in;
  logic              w_empty_sel;
  logic              w_soft_sel;
  logic              w_active;
  logic              w_capture;

  function automatic logic [NUM_CH-1:0] f_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CH; i++) oh[i] = (a == ADDR_W'(i));
    return oh;
  endfunction

  assign w_addr_oh   = f_onehot(r_addr);
  assign w_in_oh     = f_onehot(bus.data_in);
  assign w_valid_in  = ({1'b0, bus.data_in} < NUM_CH_W);
  assign w_empty_in  = |(bus.fifo_empty & w_in_oh);
  assign w_empty_sel = |(bus.fifo_empty & w_addr_oh);
  // Soft reset only counts for the channel the current packet is headed to.
  assign w_soft_sel  = |(bus.soft_reset & w_addr_oh);
  assign w_active    = (r_state != DECODE_ADDRESS) && (r_state != DROP);
  assign w_capture   = (r_state == DECODE_ADDRESS) && bus.pkt_valid;

`ifdef WAIT_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout_err;
  logic       w_timeout;
`endif

  always_comb begin
    w_next = r_state;
`ifdef WAIT_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          if (!w_valid_in)     w_next = DROP;
          else if (w_empty_in) w_next = LOAD_FIRST_DATA;
          else                 w_next = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) w_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        w_next = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) w_next = LOAD_PARITY;
        else                        w_next = LOAD_DATA;
      end
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (w_empty_sel) w_next = LOAD_FIRST_DATA;
`ifdef WAIT_TIMEOUT_EN
        else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
          w_next    = DROP;
          w_timeout = 1'b1;
        end
`endif
      end
      DROP:    if (!bus.pkt_valid) w_next = DECODE_ADDRESS;
      default: w_next = DECODE_ADDRESS;
    endcase
    if (w_active && w_soft_sel) begin
      w_next = DECODE_ADDRESS;
`ifdef WAIT_TIMEOUT_EN
      w_timeout = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= DECODE_ADDRESS;
      r_addr     <= '1;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr_err <= w_capture && !w_valid_in;
      if (w_active && w_soft_sel) r_addr <= '1;
      else if (w_capture)         r_addr <= bus.data_in;
    end
  end

`ifdef WAIT_TIMEOUT_EN
  // Counter sits at zero outside the wait state, so entry always starts from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state == WAIT_TILL_EMPTY) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                            r_wait_cnt <= 8'd0;
    end
  end
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.detect_add    = (r_state == DECODE_ADDRESS);
  assign bus.lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign bus.ld_state      = (r_state == LOAD_DATA);
  assign bus.laf_state     = (r_state == LOAD_AFTER_FULL);
  assign bus.full_state    = (r_state == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign bus.drop_state    = (r_state == DROP);
  assign bus.write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                             (r_state == LOAD_AFTER_FULL);
  assign bus.busy          = w_active && (r_state != LOAD_DATA);
  assign bus.dest_sel      = w_active ? w_addr_oh : '0;
  assign bus.addr_err      = r_addr_err;

endmodule
